// File: rtl/proc_req_ctrl_if.sv
// Processor request controller signal bundle.
// slave: controller side (commands, lookup, bus, status); master: environment side.
interface proc_req_ctrl_if #(
    parameter int ADDR_WID   = 32,
    parameter int INDEX_MSB  = 19,
    parameter int INDEX_LSB  = 2,
    parameter int TAG_MSB    = 31,
    parameter int TAG_LSB    = 20,
    parameter int OFFSET_MSB = 1,
    parameter int OFFSET_LSB = 0,
    parameter int CNT_WID    = 16
);
    logic                         cmd_rd;
    logic                         cmd_wr;
    logic [INDEX_MSB:INDEX_LSB]   index_proc;
    logic [TAG_MSB:TAG_LSB]       tag_proc;
    logic [OFFSET_MSB:OFFSET_LSB] blk_offset_proc;

    logic                         lookup_en;
    logic [INDEX_MSB:INDEX_LSB]   lookup_index;
    logic [TAG_MSB:TAG_LSB]       lookup_tag;
    logic                         lookup_done;
    logic                         lookup_hit;
    logic                         lookup_dirty;
    logic [TAG_MSB:TAG_LSB]       victim_tag;

    logic                         bus_rd;
    logic                         bus_wb;
    logic [ADDR_WID-1:0]          bus_addr;
    logic                         bus_ack;

    logic                         tag_update;
    logic                         set_dirty;
    logic                         proc_busy;
    logic                         proc_done;
    logic                         proc_hit;
    logic [OFFSET_MSB:OFFSET_LSB] blk_offset_q;
    logic                         cmd_err;
    logic [CNT_WID-1:0]           hit_cnt;
    logic [CNT_WID-1:0]           miss_cnt;

    modport slave (
        input  cmd_rd, cmd_wr, index_proc, tag_proc,
        input  blk_offset_proc,
        input  lookup_done, lookup_hit, lookup_dirty,
        input  victim_tag, bus_ack,
        output lookup_en, lookup_index, lookup_tag,
        output bus_rd, bus_wb, bus_addr,
        output tag_update, set_dirty,
        output proc_busy, proc_done, proc_hit,
        output blk_offset_q, cmd_err,
        output hit_cnt, miss_cnt
    );

    modport master (
        output cmd_rd, cmd_wr, index_proc, tag_proc,
        output blk_offset_proc,
        output lookup_done, lookup_hit, lookup_dirty,
        output victim_tag, bus_ack,
        input  lookup_en, lookup_index, lookup_tag,
        input  bus_rd, bus_wb, bus_addr,
        input  tag_update, set_dirty,
        input  proc_busy, proc_done, proc_hit,
        input  blk_offset_q, cmd_err,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/proc_req_ctrl.sv
// Cache request controller: lookup, dirty writeback, line fill, completion.
// Ports: clk, rst_n (async low), io (proc_req_ctrl_if.slave bundle).
module proc_req_ctrl #(
    parameter int ADDR_WID   = 32,
    parameter int INDEX_MSB  = 19,
    parameter int INDEX_LSB  = 2,
    parameter int TAG_MSB    = 31,
    parameter int TAG_LSB    = 20,
    parameter int OFFSET_MSB = 1,
    parameter int OFFSET_LSB = 0,
    parameter int CNT_WID    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    proc_req_ctrl_if.slave  io
);
    localparam int TAG_W = TAG_MSB - TAG_LSB + 1;
    localparam int IDX_W = INDEX_MSB - INDEX_LSB + 1;
    localparam int OFF_W = OFFSET_MSB - OFFSET_LSB + 1;
    localparam logic [CNT_WID-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITEBACK, FILL, UPDATE, DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W-1:0]   victim_q;
    logic [IDX_W-1:0]   index_q;
    logic [OFF_W-1:0]   off_q;
    logic               is_wr_q;
    logic               hit_q;
    logic               err_q;
    logic [CNT_WID-1:0] hit_cnt_q;
    logic [CNT_WID-1:0] miss_cnt_q;
    logic               cmd_any;
    logic [ADDR_WID-1:0] wb_addr;
    logic [ADDR_WID-1:0] fill_addr;

    assign cmd_any = io.cmd_rd | io.cmd_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_any) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (io.lookup_done) begin
                    if (io.lookup_hit)
                        state_nxt = is_wr_q ? UPDATE : DONE;
                    else if (io.lookup_dirty)
                        state_nxt = WRITEBACK;
                    else
                        state_nxt = FILL;
                end
            end
            WRITEBACK: begin
                if (io.bus_ack) state_nxt = FILL;
            end
            FILL: begin
                if (io.bus_ack) state_nxt = UPDATE;
            end
            UPDATE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q      <= '0;
            victim_q   <= '0;
            index_q    <= '0;
            off_q      <= '0;
            is_wr_q    <= 1'b0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (state == IDLE && cmd_any) begin
                tag_q   <= io.tag_proc;
                index_q <= io.index_proc;
                off_q   <= io.blk_offset_proc;
                // Both commands at once degrade to a read.
                is_wr_q <= io.cmd_wr & ~io.cmd_rd;
                err_q   <= io.cmd_wr & io.cmd_rd;
            end
            if (state == LOOKUP && io.lookup_done) begin
                hit_q <= io.lookup_hit;
                if (!io.lookup_hit && io.lookup_dirty)
                    victim_q <= io.victim_tag;
            end
            if (state == DONE) begin
                if (hit_q) begin
                    if (hit_cnt_q != CNT_MAX)
                        hit_cnt_q <= hit_cnt_q + 1'b1;
                end else if (miss_cnt_q != CNT_MAX) begin
                    miss_cnt_q <= miss_cnt_q + 1'b1;
                end
            end
        end
    end

    assign wb_addr   = {victim_q, index_q, {OFF_W{1'b0}}};
    assign fill_addr = {tag_q, index_q, {OFF_W{1'b0}}};

    assign io.lookup_en    = (state == LOOKUP);
    assign io.lookup_index = index_q;
    assign io.lookup_tag   = tag_q;
    assign io.bus_wb       = (state == WRITEBACK);
    assign io.bus_rd       = (state == FILL);
    assign io.bus_addr     = (state == WRITEBACK) ? wb_addr :
                             (state == FILL)      ? fill_addr : '0;
    // UPDATE is reached only after a miss or a write hit.
    assign io.tag_update   = (state == UPDATE) & ~hit_q;
    assign io.set_dirty    = (state == UPDATE) & is_wr_q;
    assign io.proc_busy    = (state != IDLE);
    assign io.proc_done    = (state == DONE);
    assign io.proc_hit     = (state == DONE) & hit_q;
    assign io.blk_offset_q = off_q;
    assign io.cmd_err      = err_q;
    assign io.hit_cnt      = hit_cnt_q;
    assign io.miss_cnt     = miss_cnt_q;
endmodule

// File: tb/tb_proc_req_ctrl.sv
// Randomized bench for proc_req_ctrl against a transaction-level model.
// Narrow counters so saturation is reached within a short run.
module tb_proc_req_ctrl;
    localparam int AW   = 32;
    localparam int IM   = 19;
    localparam int IL   = 2;
    localparam int TM   = 31;
    localparam int TL   = 20;
    localparam int OM   = 1;
    localparam int OL   = 0;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   hits_m;
    int   misses_m;

    proc_req_ctrl_if #(
        .ADDR_WID(AW), .INDEX_MSB(IM), .INDEX_LSB(IL),
        .TAG_MSB(TM), .TAG_LSB(TL),
        .OFFSET_MSB(OM), .OFFSET_LSB(OL), .CNT_WID(CW)
    ) io ();

    proc_req_ctrl #(
        .ADDR_WID(AW), .INDEX_MSB(IM), .INDEX_LSB(IL),
        .TAG_MSB(TM), .TAG_LSB(TL),
        .OFFSET_MSB(OM), .OFFSET_LSB(OL), .CNT_WID(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, obs, exp);
        end
    endtask

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic drive_idle();
        io.cmd_rd          = 1'b0;
        io.cmd_wr          = 1'b0;
        io.tag_proc        = '0;
        io.index_proc      = '0;
        io.blk_offset_proc = '0;
        io.lookup_done     = 1'b0;
        io.lookup_hit      = 1'b0;
        io.lookup_dirty    = 1'b0;
        io.victim_tag      = '0;
        io.bus_ack         = 1'b0;
    endtask

    // Called at #1 after a rising edge with the DUT idle.
    task automatic run_txn(input bit rd, input bit wr,
                           input logic [31:0] addr,
                           input bit hit, input bit dirty,
                           input logic [11:0] vtag,
                           input int ld_lat, input int wb_lat,
                           input int fill_lat);
        logic [11:0] tag;
        logic [17:0] idx;
        logic [1:0]  off;
        logic [31:0] wb_a;
        logic [31:0] rd_a;
        logic [31:0] wb_obs;
        logic [31:0] rd_obs;
        bit  is_wr;
        bit  both;
        bit  do_wb;
        bit  hit_obs;
        int  exp_done;
        int  cyc;
        int  lk;
        int  wbn;
        int  rdn;
        int  tu_n;
        int  sd_n;
        int  tu_cyc;
        int  sd_cyc;
        int  err_n;
        int  done_cyc;

        tag      = addr[31:20];
        idx      = addr[19:2];
        off      = addr[1:0];
        is_wr    = wr & ~rd;
        both     = wr & rd;
        do_wb    = !hit && dirty;
        wb_a     = {vtag, idx, 2'b00};
        rd_a     = {tag, idx, 2'b00};
        exp_done = ld_lat + (do_wb ? wb_lat : 0)
                 + (hit ? 0 : fill_lat)
                 + ((hit && !is_wr) ? 1 : 2);

        io.cmd_rd          = rd;
        io.cmd_wr          = wr;
        io.tag_proc        = tag;
        io.index_proc      = idx;
        io.blk_offset_proc = off;
        io.lookup_done     = rbit();
        io.lookup_hit      = ~hit;
        io.lookup_dirty    = rbit();
        io.bus_ack         = rbit();

        lk = 0; wbn = 0; rdn = 0;
        tu_n = 0; sd_n = 0; tu_cyc = 0; sd_cyc = 0;
        err_n = 0; done_cyc = 0; hit_obs = 1'b0;
        wb_obs = wb_a; rd_obs = rd_a;

        @(posedge clk); #1;
        cyc = 1;
        chk("busy_c1", 32'(io.proc_busy), 1);
        chk("lookup_tag", 32'(io.lookup_tag), 32'(tag));
        chk("lookup_index", 32'(io.lookup_index), 32'(idx));
        chk("blk_offset_q", 32'(io.blk_offset_q), 32'(off));

        while (1) begin
            lk  += int'(io.lookup_en);
            wbn += int'(io.bus_wb);
            rdn += int'(io.bus_rd);
            err_n += int'(io.cmd_err);
            if (io.bus_wb && io.bus_addr !== wb_a) wb_obs = io.bus_addr;
            if (io.bus_rd && io.bus_addr !== rd_a) rd_obs = io.bus_addr;
            if (io.tag_update) begin tu_n++; tu_cyc = cyc; end
            if (io.set_dirty) begin sd_n++; sd_cyc = cyc; end
            if (io.proc_done) begin
                done_cyc = cyc;
                hit_obs  = io.proc_hit;
            end

            // Commands and fields are noise while busy; none may be taken.
            io.cmd_rd          = !io.proc_done && ($urandom_range(0, 2) == 0);
            io.cmd_wr          = !io.proc_done && ($urandom_range(0, 2) == 0);
            io.tag_proc        = 12'($urandom);
            io.index_proc      = 18'($urandom);
            io.blk_offset_proc = 2'($urandom);
            if (io.lookup_en && lk == ld_lat) begin
                io.lookup_done  = 1'b1;
                io.lookup_hit   = hit;
                io.lookup_dirty = dirty;
                io.victim_tag   = vtag;
            end else begin
                io.lookup_done  = io.lookup_en ? 1'b0 : rbit();
                io.lookup_hit   = rbit();
                io.lookup_dirty = rbit();
                io.victim_tag   = 12'($urandom);
            end
            if (io.bus_wb)
                io.bus_ack = (wbn == wb_lat);
            else if (io.bus_rd)
                io.bus_ack = (rdn == fill_lat);
            else
                io.bus_ack = rbit();

            if (done_cyc != 0 || cyc >= 200) break;
            @(posedge clk); #1;
            cyc++;
        end

        chk("done_cyc", 32'(done_cyc), 32'(exp_done));
        chk("proc_hit", 32'(hit_obs), 32'(hit));
        chk("lookup_cycles", 32'(lk), 32'(ld_lat));
        chk("wb_cycles", 32'(wbn), do_wb ? 32'(wb_lat) : 32'd0);
        chk("fill_cycles", 32'(rdn), hit ? 32'd0 : 32'(fill_lat));
        if (wbn > 0) chk("wb_addr", wb_obs, wb_a);
        if (rdn > 0) chk("fill_addr", rd_obs, rd_a);
        chk("tag_update_n", 32'(tu_n), hit ? 32'd0 : 32'd1);
        chk("set_dirty_n", 32'(sd_n), 32'(is_wr));
        if (tu_n > 0) chk("tag_update_cyc", 32'(tu_cyc), 32'(exp_done - 1));
        if (sd_n > 0) chk("set_dirty_cyc", 32'(sd_cyc), 32'(exp_done - 1));
        chk("cmd_err_n", 32'(err_n), 32'(both));

        if (hit) hits_m++;
        else     misses_m++;

        @(posedge clk); #1;
        chk("idle_busy", 32'(io.proc_busy), 0);
        chk("idle_done", 32'(io.proc_done), 0);
        chk("hit_cnt", 32'(io.hit_cnt), 32'(sat(hits_m)));
        chk("miss_cnt", 32'(io.miss_cnt), 32'(sat(misses_m)));
    endtask

    task automatic reset_mid();
        int dn;
        drive_idle();
        io.cmd_rd          = 1'b1;
        io.tag_proc        = 12'h5A5;
        io.index_proc      = 18'h0F0F;
        io.blk_offset_proc = 2'h3;
        @(posedge clk); #1;
        io.cmd_rd       = 1'b0;
        io.lookup_done  = 1'b1;
        io.lookup_hit   = 1'b0;
        io.lookup_dirty = 1'b0;
        @(posedge clk); #1;
        io.lookup_done = 1'b0;
        chk("rst_pre_fill", 32'(io.bus_rd), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bus_rd", 32'(io.bus_rd), 0);
        chk("rst_busy", 32'(io.proc_busy), 0);
        chk("rst_bus_addr", io.bus_addr, 0);
        chk("rst_lookup_tag", 32'(io.lookup_tag), 0);
        chk("rst_lookup_index", 32'(io.lookup_index), 0);
        chk("rst_offset", 32'(io.blk_offset_q), 0);
        chk("rst_hit_cnt", 32'(io.hit_cnt), 0);
        chk("rst_miss_cnt", 32'(io.miss_cnt), 0);
        hits_m   = 0;
        misses_m = 0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            dn += int'(io.proc_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            dn += int'(io.proc_done);
        end
        chk("rst_no_done", 32'(dn), 0);
        chk("rst_idle", 32'(io.proc_busy), 0);
    endtask

    task automatic run_random(input int n);
        int  r;
        bit  rd;
        bit  wr;
        for (int i = 0; i < n; i++) begin
            r  = int'($urandom_range(0, 3));
            rd = (r != 2);
            wr = (r >= 2);
            run_txn(rd, wr, $urandom, rbit(), rbit(),
                    12'($urandom),
                    int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        hits_m   = 0;
        misses_m = 0;
        rst_n    = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(io.proc_busy), 0);
        chk("reset_done", 32'(io.proc_done), 0);
        chk("reset_lookup_en", 32'(io.lookup_en), 0);
        chk("reset_bus_addr", io.bus_addr, 0);
        chk("reset_hit_cnt", 32'(io.hit_cnt), 0);
        chk("reset_miss_cnt", 32'(io.miss_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 0, 32'h2333_2333, 1, 0, 12'h000, 1, 1, 1);
        run_txn(0, 1, 32'hABCD_DCBA, 0, 0, 12'h000, 1, 1, 3);
        run_txn(1, 0, 32'hFFFF_0000, 0, 1, 12'h123, 1, 2, 2);
        run_txn(1, 1, 32'h1357_9BDF, 0, 0, 12'h0AA, 2, 1, 1);
        run_txn(0, 1, 32'h0246_8ACE, 1, 1, 12'h3C3, 1, 1, 1);
        run_txn(0, 1, 32'h7777_1234, 0, 1, 12'hFED, 3, 4, 1);

        run_random(60);
        reset_mid();

        for (int i = 0; i < 5; i++)
            run_txn(1, 0, $urandom, 1, 0, 12'h000, 1, 1, 1);
        run_random(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
